// File: rtl/spi_shift_engine_if.sv
// Host-side interface of the SPI shift engine.
// Carries the transmit request (data, word size, SPI mode, chip select) and
// the receive result (data, valid pulse) plus the busy flag.
//   master : host that issues words and collects received data
//   slave  : the shift engine
interface spi_shift_engine_if;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SIZE_W  = 5;
    localparam int unsigned CSSEL_W = 2;

    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic [SIZE_W-1:0]  word_size;
    logic               cpol;
    logic               cpha;
    logic [CSSEL_W-1:0] cs_sel;
    logic               cs_auto;
    logic [DATA_W-1:0]  rx_data;
    logic               rx_valid;
    logic               busy;

    modport master (
        output tx_data, tx_valid, word_size, cpol, cpha, cs_sel, cs_auto,
        input  tx_ready, rx_data, rx_valid, busy
    );

    modport slave (
        input  tx_data, tx_valid, word_size, cpol, cpha, cs_sel, cs_auto,
        output tx_ready, rx_data, rx_valid, busy
    );
endinterface

// File: rtl/spi_shift_engine.sv
// SPI master shift engine, placed right after the baud-rate divider.
// Every toggle of the divider output (baud_in) is one SCLK half-period.
// Shifts 1..32-bit words MSB-first in any CPOL/CPHA mode, samples MISO,
// returns the received word and steers the divider enable/reset/State.
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   host           request/response interface (slave modport)
//   baud_in        divider output, one toggle per SCLK half-period
//   miso           serial input
//   sclk, mosi     serial clock and data out
//   cs_n           active-low chip selects
//   div_enable     divider enable
//   div_reset      divider reset (held during the LOAD cycle)
//   state          current FSM state, wired to the divider State input
module spi_shift_engine #(
    parameter int unsigned NUM_CS = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    spi_shift_engine_if.slave    host,
    input  logic                 baud_in,
    input  logic                 miso,
    output logic                 sclk,
    output logic                 mosi,
    output logic [NUM_CS-1:0]    cs_n,
    output logic                 div_enable,
    output logic                 div_reset,
    output logic [3:0]           state
);
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SIZE_W  = 5;
    localparam int unsigned CSSEL_W = 2;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'hA,
        ST_LOAD  = 4'h1,
        ST_SETUP = 4'h2,
        ST_LEAD  = 4'h3,
        ST_TRAIL = 4'h4,
        ST_HOLD  = 4'h5
    } state_e;

    state_e              state_q;
    logic                baud_q;
    logic                tick;
    logic [DATA_W-1:0]   tx_sh;
    logic [DATA_W-1:0]   rx_sh;
    logic [SIZE_W-1:0]   bitcnt;
    logic                cpol_q;
    logic                cpha_q;
    logic [CSSEL_W-1:0]  cs_sel_q;
    logic                cs_auto_q;
    logic [DATA_W-1:0]   rx_data_q;
    logic                rx_valid_q;

    // One half-period elapsed whenever the divider output changed.
    assign tick = baud_in ^ baud_q;

    assign state         = 4'(state_q);
    assign host.tx_ready = (state_q == ST_IDLE) & ~reset;
    assign host.busy     = (state_q != ST_IDLE);
    assign host.rx_data  = rx_data_q;
    assign host.rx_valid = rx_valid_q;

    // Transfer sequencer.
    // SETUP burns the first tick so MOSI has a half-period of setup before
    // the first edge; LEAD/TRAIL wait for the tick that makes the leading /
    // trailing SCLK edge; HOLD burns the last tick before releasing CS.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            cs_n       <= '1;
            rx_valid_q <= 1'b0;
            div_enable <= 1'b0;
            div_reset  <= 1'b0;
            baud_q     <= 1'b0;
            // An aborted transfer keeps the last delivered word visible.
            if (state_q == ST_IDLE) begin
                rx_data_q <= '0;
            end
        end else begin
            baud_q     <= baud_in;
            rx_valid_q <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    sclk <= host.cpol;
                    if (host.tx_valid) begin
                        cpol_q     <= host.cpol;
                        cpha_q     <= host.cpha;
                        cs_sel_q   <= host.cs_sel;
                        cs_auto_q  <= host.cs_auto;
                        // Left-align the word so the MSB to send sits at bit 31.
                        tx_sh      <= host.tx_data << (5'd31 - host.word_size);
                        rx_sh      <= '0;
                        bitcnt     <= host.word_size;
                        div_enable <= 1'b1;
                        div_reset  <= 1'b1;
                        state_q    <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    // Divider output restarts from 0, so no stale tick is seen.
                    baud_q    <= 1'b0;
                    div_reset <= 1'b0;
                    if (cs_auto_q) begin
                        cs_n <= ~(NUM_CS'(1) << cs_sel_q);
                    end
                    mosi    <= tx_sh[DATA_W-1];
                    state_q <= ST_SETUP;
                end

                ST_SETUP: begin
                    if (tick) begin
                        state_q <= ST_LEAD;
                    end
                end

                ST_LEAD: begin
                    if (tick) begin
                        sclk <= ~cpol_q;
                        if (!cpha_q) begin
                            rx_sh <= {rx_sh[DATA_W-2:0], miso};
                        end else begin
                            // CPHA=1 launches the current MSB on the leading edge.
                            mosi  <= tx_sh[DATA_W-1];
                            tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
                        end
                        state_q <= ST_TRAIL;
                    end
                end

                ST_TRAIL: begin
                    if (tick) begin
                        sclk <= cpol_q;
                        if (!cpha_q) begin
                            mosi  <= tx_sh[DATA_W-2];
                            tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
                        end else begin
                            rx_sh <= {rx_sh[DATA_W-2:0], miso};
                        end
                        if (bitcnt == '0) begin
                            state_q <= ST_HOLD;
                        end else begin
                            bitcnt  <= bitcnt - SIZE_W'(1);
                            state_q <= ST_LEAD;
                        end
                    end
                end

                ST_HOLD: begin
                    if (tick) begin
                        cs_n       <= '1;
                        div_enable <= 1'b0;
                        rx_data_q  <= rx_sh;
                        rx_valid_q <= 1'b1;
                        mosi       <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
